// File: rtl/switch_conditioner_pkg.sv
// Shared types and defaults for the picomips input-conditioning logic.
// Holds the SW8 debounce state encoding and the default synchroniser/debounce sizes.
package picomips_pkg;

    typedef enum logic [1:0] {
        LO      = 2'd0,
        PEND_HI = 2'd1,
        HI      = 2'd2,
        PEND_LO = 2'd3
    } sw_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;

    // The debounced level is high while settled high or while a fall is still pending
    function automatic logic is_high(input sw_state_t s);
        return (s == HI) || (s == PEND_LO);
    endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch-side bundle of the conditioner: raw bank in, conditioned bus and edge pulses out.
interface switch_conditioner_if;
    logic [8:0] SW_raw;
    logic [9:0] SW_clean;
    logic       Sw8_rise;
    logic       Sw8_fall;

    modport master (output SW_raw, input SW_clean, Sw8_rise, Sw8_fall);
    modport slave  (input SW_raw, output SW_clean, Sw8_rise, Sw8_fall);
endinterface

// File: rtl/switch_conditioner_sync_ff.sv
// N-stage, W-bit flip-flop synchroniser with asynchronous active-low clear.
module sync_ff #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_r [N];

    // Shift chain: stage 0 samples the asynchronous input, the last stage is the output
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < N; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < N; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[N-1];

endmodule

// File: rtl/switch_conditioner.sv
// Synchronises the board switches, debounces SW8, freezes the data byte while SW8 is
// high and produces the synchronised core reset on SW_clean[9].
module switch_conditioner
    import picomips_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 16
) (
    input  logic                 Clock,
    input  logic                 nReset,
    switch_conditioner_if.slave  sw
);

    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               DIRECT    = (DEBOUNCE_CYCLES == 32'sd1);

    logic [8:0]       sw_sync_s;
    logic             core_rst_n_s;
    logic             s8_s;
    logic [7:0]       sdata_s;
    sw_state_t        state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             rise_s, fall_s, load_s;
    logic             sw8_r, rise_r, fall_r;
    logic [7:0]       data_r;

    sync_ff #(.N(SYNC_STAGES), .W(9)) u_sw_sync (
        .Clock  (Clock),
        .nReset (nReset),
        .d      (sw.SW_raw),
        .q      (sw_sync_s)
    );

    sync_ff #(.N(SYNC_STAGES), .W(1)) u_rst_sync (
        .Clock  (Clock),
        .nReset (nReset),
        .d      (1'b1),
        .q      (core_rst_n_s)
    );

    assign s8_s    = sw_sync_s[8];
    assign sdata_s = sw_sync_s[7:0];

    // SW8 debounce next-state, counter and edge-pulse decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rise_s      = 1'b0;
        fall_s      = 1'b0;
        case (state_r)
            LO: begin
                if (s8_s) begin
                    if (DIRECT) begin
                        state_nxt_s = HI;
                        cnt_nxt_s   = '0;
                        rise_s      = 1'b1;
                    end else begin
                        state_nxt_s = PEND_HI;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = '0;
                end
            end
            PEND_HI: begin
                if (!s8_s) begin
                    state_nxt_s = LO;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == DEB_LIMIT) begin
                    state_nxt_s = HI;
                    cnt_nxt_s   = '0;
                    rise_s      = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            HI: begin
                if (!s8_s) begin
                    if (DIRECT) begin
                        state_nxt_s = LO;
                        cnt_nxt_s   = '0;
                        fall_s      = 1'b1;
                    end else begin
                        state_nxt_s = PEND_LO;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = '0;
                end
            end
            PEND_LO: begin
                if (s8_s) begin
                    state_nxt_s = HI;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == DEB_LIMIT) begin
                    state_nxt_s = LO;
                    cnt_nxt_s   = '0;
                    fall_s      = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = LO;
                cnt_nxt_s   = '0;
            end
        endcase
        // Latch stays open on the edge that enters HI and on the edge that returns to LO
        load_s = !is_high(state_r) || !is_high(state_nxt_s);
    end

    // State, counter and registered outputs
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r <= LO;
            cnt_r   <= '0;
            sw8_r   <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            data_r  <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sw8_r   <= is_high(state_nxt_s);
            rise_r  <= rise_s;
            fall_r  <= fall_s;
            if (load_s) begin
                data_r <= sdata_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign sw.SW_clean = {core_rst_n_s, sw8_r, data_r};
    assign sw.Sw8_rise = rise_r;
    assign sw.Sw8_fall = fall_r;

endmodule

// File: tb/tb_switch_conditioner.sv
// Randomised and directed bench for switch_conditioner (DEBOUNCE_CYCLES=4 and =1) against
// a behavioural run-length model of synchronisation, debounce and data freezing.
module tb_switch_conditioner;

    localparam int SYNC = 2;
    localparam int DEB [2] = '{4, 1};

    logic       Clock  = 1'b0;
    logic       nReset = 1'b0;
    logic [8:0] sw_raw = 9'h000;
    int         errors = 0;
    int         checks = 0;
    int         n;
    bit         seen;

    switch_conditioner_if if0 ();
    switch_conditioner_if if1 ();

    switch_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut0 (
        .Clock  (Clock),
        .nReset (nReset),
        .sw     (if0.slave)
    );

    switch_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1), .CNT_W(16)) dut1 (
        .Clock  (Clock),
        .nReset (nReset),
        .sw     (if1.slave)
    );

    always #5 Clock = ~Clock;

    // Reference model: a SYNC-deep delay line, then a run of disagreeing samples that
    // must reach DEB+1 (or 1 when DEB==1) before the level flips
    logic [8:0] m_pipe [2][SYNC];
    logic       m_level [2];
    int         m_run [2];
    logic [7:0] m_data [2];
    logic       m_rise [2];
    logic       m_fall [2];
    int         m_rel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < SYNC; j++) m_pipe[k][j] = 9'h000;
            m_level[k] = 1'b0;
            m_run[k]   = 0;
            m_data[k]  = 8'h00;
            m_rise[k]  = 1'b0;
            m_fall[k]  = 1'b0;
        end
        m_rel = 0;
    endtask

    task automatic model_step();
        logic [8:0] s;
        logic       old;
        int         need;
        if (!nReset) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                s    = m_pipe[k][SYNC-1];
                old  = m_level[k];
                need = (DEB[k] == 1) ? 1 : DEB[k] + 1;
                m_rise[k] = 1'b0;
                m_fall[k] = 1'b0;
                if (s[8] != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] >= need) begin
                        m_level[k] = s[8];
                        m_run[k]   = 0;
                        m_rise[k]  = s[8];
                        m_fall[k]  = !s[8];
                    end
                end else begin
                    m_run[k] = 0;
                end
                if (!old || !m_level[k]) m_data[k] = s[7:0];
                for (int j = SYNC - 1; j > 0; j--) m_pipe[k][j] = m_pipe[k][j-1];
                m_pipe[k][0] = sw_raw;
            end
            if (m_rel < SYNC) m_rel++;
        end
    endtask

    function automatic logic [11:0] model_word(input int k);
        return {(m_rel >= SYNC), m_level[k], m_data[k], m_rise[k], m_fall[k]};
    endfunction

    task automatic compare_all();
        chk("dut0_outputs", {if0.SW_clean, if0.Sw8_rise, if0.Sw8_fall}, model_word(0));
        chk("dut1_outputs", {if1.SW_clean, if1.Sw8_rise, if1.Sw8_fall}, model_word(1));
    endtask

    task automatic set_raw(input logic [8:0] v);
        sw_raw     = v;
        if0.SW_raw = v;
        if1.SW_raw = v;
    endtask

    task automatic cycle();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        compare_all();
    endtask

    // Count edges until DUT0 pulses the requested edge, bounded at 20
    task automatic wait_pulse(input bit want_fall, output int edges);
        edges = 0;
        do begin
            cycle();
            edges++;
        end while (!(want_fall ? if0.Sw8_fall : if0.Sw8_rise) && edges < 20);
    endtask

    initial begin
        set_raw(9'h1FF);
        model_reset();
        #1;
        compare_all();
        chk("reset_clean", if0.SW_clean, 10'h000);
        repeat (3) cycle();
        nReset = 1'b1;
        cycle();
        chk("rst_edge1", if0.SW_clean[9], 1'b0);
        cycle();
        chk("rst_edge2", if0.SW_clean[9], 1'b1);
        repeat (4) cycle();
        chk("sw8_low_6", if0.SW_clean[8], 1'b0);
        set_raw(9'h000);
        repeat (20) cycle();

        // clean press
        set_raw(9'h05A);
        repeat (4) cycle();
        set_raw(9'h15A);
        wait_pulse(1'b0, n);
        chk("press_lat", n, 7);
        chk("press_data", if0.SW_clean[7:0], 8'h5A);
        set_raw(9'h05A);
        repeat (15) cycle();

        // bounce: 3 high, 1 low, then held high
        set_raw(9'h15A);
        repeat (3) begin cycle(); chk("bounce_norise", if0.Sw8_rise, 1'b0); end
        set_raw(9'h05A);
        cycle();
        chk("bounce_norise", if0.Sw8_rise, 1'b0);
        set_raw(9'h15A);
        wait_pulse(1'b0, n);
        chk("bounce_lat", n, 7);

        // freeze and release
        set_raw(9'h1FF);
        repeat (6) cycle();
        chk("freeze_data", if0.SW_clean[7:0], 8'h5A);
        set_raw(9'h0FF);
        wait_pulse(1'b1, n);
        chk("fall_lat", n, 7);
        chk("fall_data", if0.SW_clean[7:0], 8'hFF);
        repeat (4) cycle();

        // reset while pending high with cnt=3
        set_raw(9'h13C);
        repeat (5) cycle();
        nReset = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("midrst_clean", if0.SW_clean, 10'h000);
        repeat (2) cycle();
        nReset = 1'b1;
        wait_pulse(1'b0, n);
        chk("midrst_lat", n, 7);

        // minimum debounce on dut1: one-cycle SW8 pulse
        set_raw(9'h000);
        repeat (12) cycle();
        set_raw(9'h100);
        cycle();
        set_raw(9'h000);
        seen = 1'b0;
        repeat (6) begin
            cycle();
            if (if1.Sw8_rise && if1.SW_clean[8]) seen = 1'b1;
        end
        chk("min_deb_rise", seen, 1'b1);

        // randomised traffic with occasional resets
        repeat (600) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10) set_raw({~sw_raw[8], sw_raw[7:0]});
            else if (r < 20) set_raw({sw_raw[8], 8'($urandom)});
            else if (r == 99) begin
                nReset = 1'b0;
                model_reset();
                #1;
                compare_all();
                cycle();
                nReset = 1'b1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
